mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the processor's single-port, synchronous-read data/instruction memory between the CPU multicycle controller (fetch, load, store) and an external requester (loader/IO/DMA port). It latches the winning request, drives the memory for one access cycle, returns a one-cycle ready pulse to the winner and a read-valid pulse one cycle later. It sits between the controller/datapath memory signals and the memory block.

## Interface
- WIDTH, 16, data width
- ADDR_WIDTH, 16, address width
- MAX_BURST, 4, max consecutive locked external grants while CPU waits (≥1)

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request (level, held until cpu_ready)
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_WIDTH  CPU address
- cpu_wdata  input  WIDTH  CPU write data
- cpu_ready  output  1  one-cycle pulse: CPU access executing this cycle
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid (reads only)
- cpu_rdata  output  WIDTH  read data
- ext_req, ext_we, ext_addr, ext_wdata  input  1/1/ADDR_WIDTH/WIDTH  external request, same rules as CPU
- ext_lock  input  1  external asks to keep priority for next access
- ext_gnt  output  1  one-cycle pulse: external access executing this cycle
- ext_rvalid  output  1  one-cycle pulse: ext_rdata valid
- ext_rdata  output  WIDTH  read data
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_we  output  1  memory write enable
- mem_rdata  input  WIDTH  memory read data, valid cycle after address

## Operation
- FSM states: IDLE, CPU_ACC, EXT_ACC. Reset → IDLE.
- IDLE: at clock edge, sample requests. None → stay IDLE. One → its ACC state. Both → winner per priority rule (Configuration), lock overrides.
- On entering ACC: latch winner's we/addr/wdata into registers; mem_addr/mem_wdata/mem_we driven from latch; mem_we high only in ACC state of a write.
- ACC state lasts exactly one cycle; cpu_ready or ext_gnt high for that cycle; always returns to IDLE.
- Read: owner tag registered at end of ACC; in following cycle {cpu|ext}_rvalid = 1 and {cpu|ext}_rdata = mem_rdata. Non-owner rdata = 0. Writes produce no rvalid.
- Requester deasserts or changes request at the edge ending its ready/gnt cycle; since sampling occurs only in IDLE, no double issue.
- Lock: if last grant was EXT and ext_lock && ext_req sampled in IDLE and burst_cnt < MAX_BURST, EXT wins regardless of cpu_req.
- burst_cnt: increments on each EXT grant won while cpu_req=1; clears on any CPU grant or when cpu_req=0 at arbitration. At MAX_BURST, lock ignored; CPU wins if requesting.
- mem_addr/mem_wdata hold last latched values in IDLE; mem_we = 0 in IDLE.

## Timing
- Reset (reset=0): immediate; state IDLE, all outputs 0, latches, owner tag, burst_cnt, rr pointer cleared. In-flight access aborted: mem_we falls at once, no rvalid issued.
- Request visible before edge n (FSM in IDLE) → ACC during cycle n..n+1 → rvalid during n+1..n+2.
- Throughput: one access per 2 cycles maximum. Loser waits ≥2 cycles.
- Request rising while FSM in ACC: first sampled at the IDLE edge that follows.
- All outputs registered or decoded from registered state only; no combinational path from any *_req to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: simultaneous unlocked requests go to requester not served in most recent grant (1-bit last-served pointer, reset = EXT so CPU wins first tie).
- Undefined: fixed priority; CPU always wins unlocked ties; pointer logic absent.
- Lock and burst limit behave identically in both builds.

## Test plan
- Reset: hold reset=0 with cpu_req=ext_req=1 → all outputs 0, no ready/gnt; release → CPU granted at first IDLE edge.
- CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=0x0010, mem[0x0010]=0xBEEF → cpu_ready cycle 1 with mem_addr=0x0010, mem_we=0; cpu_rvalid cycle 2, cpu_rdata=0xBEEF; ext_rvalid=0.
- Tie, macro undefined: both request continuously, CPU write 0x0020←0x1234, EXT read 0x0030 → grants CPU, CPU, CPU…; EXT starves until cpu_req drops, then ext_gnt next arbitration.
- Tie, ARB_ROUND_ROBIN_EN: both request continuously → grants alternate CPU, EXT, CPU, EXT every 2 cycles.
- Lock burst, MAX_BURST=4: EXT holds ext_req/ext_lock, CPU requests after first EXT grant → exactly 4 consecutive ext_gnt, then cpu_ready, then EXT.
- Reset mid-write: reset=0 during EXT_ACC with ext_we=1 → mem_we falls same cycle, ext_gnt=0, no rvalid; after release FSM in IDLE, burst_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/external arbiter for the shared single-port synchronous-read memory
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build uses fixed CPU priority.
module mem_port_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [WIDTH-1:0]      cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0]      ext_wdata,
  input  logic                  ext_lock,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [WIDTH-1:0]      ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int            BW      = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          last_ext;
  logic          tie_cpu;
  logic          lock_win;
  logic          grant_cpu;
  logic          grant_ext;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-served pointer; resets to EXT so the CPU takes the first tie.
  logic rr_last_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_ext <= 1'b1;
    end else if (state == IDLE && (grant_cpu || grant_ext)) begin
      rr_last_ext <= grant_ext;
    end
  end

  assign tie_cpu = rr_last_ext;
`else
  assign tie_cpu = 1'b1;
`endif

  always_comb begin
    lock_win  = last_ext && ext_lock && ext_req && (burst_cnt < MAX_CNT);
    grant_cpu = !lock_win && cpu_req && (!ext_req || tie_cpu);
    grant_ext = ext_req && !grant_cpu;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_ext   <= 1'b0;
      cpu_ready  <= 1'b0;
      ext_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_ready  <= 1'b0;
      ext_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state     <= CPU_ACC;
            cpu_ready <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            last_ext  <= 1'b0;
            burst_cnt <= '0;
          end else if (grant_ext) begin
            state     <= EXT_ACC;
            ext_gnt   <= 1'b1;
            mem_we    <= ext_we;
            mem_addr  <= ext_addr;
            mem_wdata <= ext_wdata;
            last_ext  <= 1'b1;
            // Only grants taken while the CPU is waiting count toward the burst limit.
            if (!cpu_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != MAX_CNT) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else begin
            burst_cnt <= '0;
          end
        end
        CPU_ACC: begin
          state      <= IDLE;
          cpu_rvalid <= !mem_we;
        end
        EXT_ACC: begin
          state      <= IDLE;
          ext_rvalid <= !mem_we;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
// Honours ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_ready, cpu_rvalid, ext_gnt, ext_rvalid, mem_we;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_init;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(int i);
    if (i == 16'h0010) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model: which requester owns the memory this cycle (0 none, 1 CPU, 2 EXT) and its access.
  int          owner;
  logic        a_we;
  logic [15:0] a_addr, a_wdata;
  bit          last_ext, rr_ext;
  int          burst;
  bit          e_ready, e_gnt, e_we, e_cpu_rv, e_ext_rv;
  logic [15:0] e_rval;
  int          glog[$];
  bit          cpu_left, ext_left;

  logic        s_rst, s_cr, s_cwe, s_er, s_ewe, s_el;
  logic [15:0] s_ca, s_cwd, s_ea, s_ewd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    last_ext = 0; rr_ext = 1; burst = 0;
    e_ready = 0; e_gnt = 0; e_we = 0; e_cpu_rv = 0; e_ext_rv = 0; e_rval = 0;
  endtask

  task automatic model_edge();
    int who;
    e_ready = 0; e_gnt = 0; e_we = 0; e_cpu_rv = 0; e_ext_rv = 0;
    if (owner != 0) begin
      if (a_we) ref_mem[a_addr] = a_wdata;
      else begin
        e_rval = ref_mem[a_addr];
        if (owner == 1) e_cpu_rv = 1; else e_ext_rv = 1;
      end
      if (owner == 1) cpu_left = 1; else ext_left = 1;
      owner = 0;
    end else begin
      who = 0;
      if (last_ext && s_el && s_er && burst < MAXB) who = 2;
      else if (s_cr && s_er) who = RR ? (rr_ext ? 1 : 2) : 1;
      else if (s_cr) who = 1;
      else if (s_er) who = 2;
      if (!s_cr || who == 1) burst = 0;
      else if (who == 2 && burst < MAXB) burst++;
      if (who != 0) begin
        owner = who;
        a_we    = (who == 1) ? s_cwe : s_ewe;
        a_addr  = (who == 1) ? s_ca  : s_ea;
        a_wdata = (who == 1) ? s_cwd : s_ewd;
        last_ext = (who == 2);
        rr_ext   = (who == 2);
        e_ready = (who == 1);
        e_gnt   = (who == 2);
        e_we    = a_we;
        glog.push_back(who);
      end
    end
  endtask

  task automatic step();
    s_rst = reset; s_cr = cpu_req; s_cwe = cpu_we; s_ca = cpu_addr; s_cwd = cpu_wdata;
    s_er = ext_req; s_ewe = ext_we; s_ea = ext_addr; s_ewd = ext_wdata; s_el = ext_lock;
    @(posedge clk); #1;
    if (!s_rst) model_reset(); else model_edge();
    chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
    chk("ext_gnt", 32'(ext_gnt), 32'(e_gnt));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(a_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(a_wdata));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cpu_rv));
    chk("ext_rvalid", 32'(ext_rvalid), 32'(e_ext_rv));
    chk("cpu_rdata", 32'(cpu_rdata), e_cpu_rv ? 32'(e_rval) : 32'd0);
    chk("ext_rdata", 32'(ext_rdata), e_ext_rv ? 32'(e_rval) : 32'd0);
  endtask

  task automatic go_idle();
    cpu_req = 0; ext_req = 0; ext_lock = 0;
    step(); step();
  endtask

  task automatic drive_random();
    if (!reset) reset = 1;
    else if ($urandom_range(0, 399) == 0) reset = 0;
    if (cpu_left) begin cpu_left = 0; cpu_req = 0; end
    if (ext_left) begin ext_left = 0; ext_req = 0; end
    if (!cpu_req && $urandom_range(0, 99) < 45) begin
      cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom_range(0, 255)); cpu_wdata = 16'($urandom);
    end
    if (!ext_req && $urandom_range(0, 99) < 55) begin
      ext_req = 1; ext_we = 1'($urandom_range(0, 1));
      ext_addr = 16'($urandom_range(0, 255)); ext_wdata = 16'($urandom);
    end
    ext_lock = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    int k, n_ext, n_cpu;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    model_reset();
    cpu_left = 0; ext_left = 0;
    mem_init = 1;
    reset = 0; ext_lock = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
    ext_req = 1; ext_we = 0; ext_addr = 16'h0030; ext_wdata = 16'h0000;

    // Reset held with both requesting: nothing may be granted.
    step();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_gnt", 32'(ext_gnt), 32'd0);
    step(); step();
    mem_init = 0;
    reset = 1;
    step();
    chk("first_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("first_ext_gnt", 32'(ext_gnt), 32'd0);
    chk("first_addr", 32'(mem_addr), 32'h0010);
    step();
    chk("beef_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("beef_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("beef_ext_rvalid", 32'(ext_rvalid), 32'd0);
    cpu_req = 0;
    step();
    chk("ext_after_cpu", 32'(ext_gnt), 32'd1);
    go_idle();

    // Continuous tie: CPU write 0x0020<-0x1234, EXT read 0x0030.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    ext_req = 1; ext_we = 0; ext_addr = 16'h0030; ext_lock = 0;
    glog.delete();
    for (int i = 0; i < 12; i++) step();
    n_ext = 0; n_cpu = 0;
    foreach (glog[i]) if (glog[i] == 2) n_ext++; else n_cpu++;
    chk("tie_grants", 32'(glog.size()), 32'd6);
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_rr_ext", 32'(n_ext), 32'd3);
    chk("tie_rr_cpu", 32'(n_cpu), 32'd3);
`else
    chk("tie_fixed_ext", 32'(n_ext), 32'd0);
    chk("tie_fixed_cpu", 32'(n_cpu), 32'd6);
`endif
    cpu_req = 0;
    step();
    chk("tie_ext_after_drop", 32'(ext_gnt), 32'd1);
    step();
    chk("tie_ext_rdata", 32'(ext_rdata), 32'(init_val(16'h0030)));
    go_idle();

    // Locked external burst with the CPU waiting.
    ext_req = 1; ext_lock = 1; ext_we = 0; ext_addr = 16'h0060; cpu_req = 0;
    glog.delete();
    step();
    chk("lock_first", 32'(ext_gnt), 32'd1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    k = 0;
    while (!(glog.size() > 0 && glog[$] == 1) && k < 40) begin step(); k++; end
    chk("lock_cpu_served", 32'(glog.size() > 0 && glog[$] == 1), 32'd1);
    n_ext = 0;
    foreach (glog[i]) if (glog[i] == 2) n_ext++;
    chk("lock_burst_len", 32'(n_ext - 1), 32'd4);
    step();
    cpu_req = 0;
    step();
    chk("lock_ext_after_cpu", 32'(ext_gnt), 32'd1);
    step();
    ext_req = 0; ext_lock = 0;
    go_idle();

    // Reset asserted in the middle of an external write.
    ext_req = 1; ext_we = 1; ext_addr = 16'h0050; ext_wdata = 16'hCAFE; ext_lock = 0;
    step();
    chk("mw_gnt", 32'(ext_gnt), 32'd1);
    chk("mw_we", 32'(mem_we), 32'd1);
    #2;
    reset = 0;
    #1;
    chk("mw_we_abort", 32'(mem_we), 32'd0);
    chk("mw_gnt_abort", 32'(ext_gnt), 32'd0);
    model_reset();
    ext_req = 0;
    step(); step();
    reset = 1;
    step();
    chk("mw_burst_clr", 32'(dut.burst_cnt), 32'd0);
    ext_req = 1; ext_we = 0; ext_addr = 16'h0050;
    step();
    step();
    chk("mw_not_written", 32'(ext_rdata), 32'(init_val(16'h0050)));
    go_idle();

    // Randomized traffic against the model.
    cpu_left = 0; ext_left = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
